// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg : shared constants and rounding/saturation helper for the SDF FFT
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fft_pkg;

  localparam int FFT_N   = 64;
  localparam int DATA_W  = 16;
  localparam int TW_W    = 8;
  localparam int TW_FRAC = 6;
  localparam int ADDR_W  = $clog2(FFT_N);

  localparam int PROD_W  = DATA_W + TW_W;
  localparam int SUM_W   = PROD_W + 1;

  localparam logic signed [SUM_W:0]    RND_HALF = (SUM_W + 1)'(2 ** (TW_FRAC - 1));
  localparam logic signed [DATA_W-1:0] SAT_HI   = {1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_LO   = {1'b1, {(DATA_W - 1){1'b0}}};

  // Round half-up by TW_FRAC bits, then clip to the DATA_W signed range.
  function automatic logic signed [DATA_W-1:0] sat_round(input logic signed [SUM_W-1:0] x);
    logic signed [SUM_W:0] r;
    r = ($signed({x[SUM_W-1], x}) + RND_HALF) >>> TW_FRAC;
    if (r > SAT_HI) begin
      return SAT_HI;
    end else if (r < SAT_LO) begin
      return SAT_LO;
    end
    return r[DATA_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmult_pipe.sv
// ---------------------------------------------------------------------------
// cmult_pipe : 2-stage complex multiply, round half-up and saturate
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cmult_pipe
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mul_en,
  input  logic                     out_en,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [TW_W-1:0]   w_re,
  input  logic signed [TW_W-1:0]   w_im,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im
);

  logic signed [PROD_W-1:0] ac;
  logic signed [PROD_W-1:0] bd;
  logic signed [PROD_W-1:0] ad;
  logic signed [PROD_W-1:0] bc;
  logic signed [SUM_W-1:0]  re_sum;
  logic signed [SUM_W-1:0]  im_sum;

  function automatic logic signed [PROD_W-1:0] smul(
    input logic signed [DATA_W-1:0] d,
    input logic signed [TW_W-1:0]   w
  );
    return $signed({{(PROD_W - DATA_W){d[DATA_W-1]}}, d}) *
           $signed({{(PROD_W - TW_W){w[TW_W-1]}}, w});
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      ac <= '0;
      bd <= '0;
      ad <= '0;
      bc <= '0;
    end else if (mul_en) begin
      ac <= smul(a_re, w_re);
      bd <= smul(a_im, w_im);
      ad <= smul(a_re, w_im);
      bc <= smul(a_im, w_re);
    end
  end

  assign re_sum = {ac[PROD_W-1], ac} - {bd[PROD_W-1], bd};
  assign im_sum = {ad[PROD_W-1], ad} + {bc[PROD_W-1], bc};

  // Output only updates on valid data so it holds across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_re <= '0;
      out_im <= '0;
    end else if (out_en) begin
      out_re <= sat_round(re_sum);
      out_im <= sat_round(im_sum);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sdf_twiddle_mult.sv
// ---------------------------------------------------------------------------
// sdf_twiddle_mult : SDF FFT twiddle stage, ROM addressing and data alignment
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sdf_twiddle_mult
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic [ADDR_W-1:0]        addr,
  input  logic signed [TW_W-1:0]   twiddle_re,
  input  logic signed [TW_W-1:0]   twiddle_im,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic                     out_sof
);

  logic [ADDR_W-1:0]        cnt;
  logic                     v1;
  logic                     v2;
  logic                     v3;
  logic                     sof1;
  logic                     sof2;
  logic                     sof3;
  logic signed [DATA_W-1:0] d_re;
  logic signed [DATA_W-1:0] d_im;

  // Data is registered on the same edge the ROM samples addr, so both
  // arrive together one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      sof1 <= 1'b0;
      sof2 <= 1'b0;
      sof3 <= 1'b0;
      d_re <= '0;
      d_im <= '0;
    end else begin
      v1   <= in_valid;
      v2   <= v1;
      v3   <= v2;
      sof1 <= in_valid && (cnt == '0);
      sof2 <= sof1;
      sof3 <= sof2;
      if (in_valid) begin
        cnt  <= cnt + ADDR_W'(1);
        d_re <= in_re;
        d_im <= in_im;
      end
    end
  end

  assign addr      = cnt;
  assign out_valid = v3;
  assign out_sof   = sof3;

  cmult_pipe u_cmult (
    .clk    (clk),
    .rst    (rst),
    .mul_en (v1),
    .out_en (v2),
    .a_re   (d_re),
    .a_im   (d_im),
    .w_re   (twiddle_re),
    .w_im   (twiddle_im),
    .out_re (out_re),
    .out_im (out_im)
  );

endmodule

`default_nettype wire

// File: tb/tb_sdf_twiddle_mult.sv
// ---------------------------------------------------------------------------
// tb_sdf_twiddle_mult : self-checking bench with stub ROM and reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_sdf_twiddle_mult;

  localparam int N = 64;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [15:0] in_re = '0;
  logic signed [15:0] in_im = '0;
  logic [5:0]         addr;
  logic signed [7:0]  twiddle_re;
  logic signed [7:0]  twiddle_im;
  logic               out_valid;
  logic signed [15:0] out_re;
  logic signed [15:0] out_im;
  logic               out_sof;

  logic signed [7:0]  rom_re [N];
  logic signed [7:0]  rom_im [N];

  int checks = 0;
  int failures = 0;

  typedef struct {
    int due;
    int re;
    int im;
    bit sof;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   k = 0;
  bit   mon_en = 1'b0;
  bit   rst_hit = 1'b0;
  logic signed [15:0] last_re = '0;
  logic signed [15:0] last_im = '0;

  sdf_twiddle_mult dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_re      (in_re),
    .in_im      (in_im),
    .addr       (addr),
    .twiddle_re (twiddle_re),
    .twiddle_im (twiddle_im),
    .out_valid  (out_valid),
    .out_re     (out_re),
    .out_im     (out_im),
    .out_sof    (out_sof)
  );

  always #5 clk = ~clk;

  // Stub ROM with one cycle of read latency.
  always @(posedge clk) begin
    twiddle_re <= rom_re[addr];
    twiddle_im <= rom_im[addr];
  end

  // Real-valued product scaled by 1/64, rounded half-up, clipped to 16 bits.
  function automatic int ref_scale(input longint v);
    real r;
    r = $floor(real'(v) / 64.0 + 0.5);
    if (r > 32767.0) return 32767;
    if (r < -32768.0) return -32768;
    return int'(r);
  endfunction

  // Reference model: each accepted sample pairs with ROM[k] and is due 3 cycles later.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_hit <= rst;
    if (rst) begin
      mon_en <= 1'b1;
      k      <= 0;
      q.delete();
    end else if (in_valid) begin
      q.push_back('{due: cyc + 3,
                    re:  ref_scale(longint'(in_re) * rom_re[k] - longint'(in_im) * rom_im[k]),
                    im:  ref_scale(longint'(in_re) * rom_im[k] + longint'(in_im) * rom_re[k]),
                    sof: (k == 0)});
      k <= (k + 1) % N;
    end
  end

  task automatic drive(input bit v, input logic signed [15:0] re, input logic signed [15:0] im);
    @(negedge clk);
    in_valid = v;
    in_re    = re;
    in_im    = im;
  endtask

  // Reset with in_valid held high to show it is ignored during rst.
  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_re    = 16'($urandom);
    in_im    = 16'($urandom);
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic fill_rom(input bit rnd, input logic signed [7:0] re, input logic signed [7:0] im);
    for (int i = 0; i < N; i++) begin
      rom_re[i] = rnd ? 8'($urandom) : re;
      rom_im[i] = rnd ? 8'($urandom) : im;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_re !== 16'sd0 || out_im !== 16'sd0 || addr !== 6'd0)
      begin failures++; $display("FAIL reset: valid=%b sof=%b re=%0d im=%0d addr=%0d, want all 0", out_valid, out_sof, out_re, out_im, addr); end
  endtask

  task automatic test_identity();
    fill_rom(1'b1, 8'sd0, 8'sd0);
    rom_re[0] = 8'sd64;
    rom_im[0] = 8'sd0;
    do_reset();
    drive(1'b1, 16'sd1000, -16'sd2000);
    drive(1'b0, 16'sd0, 16'sd0);
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_sof !== 1'b1 || out_re !== 16'sd1000 || out_im !== -16'sd2000)
      begin failures++; $display("FAIL identity: valid=%b sof=%b out=(%0d,%0d), want 1 1 (1000,-2000)", out_valid, out_sof, out_re, out_im); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_re !== 16'sd1000 || out_im !== -16'sd2000)
      begin failures++; $display("FAIL hold: valid=%b out=(%0d,%0d), want 0 (1000,-2000)", out_valid, out_re, out_im); end
  endtask

  task automatic test_minus_j();
    fill_rom(1'b0, 8'sd0, -8'sd64);
    do_reset();
    drive(1'b1, 16'sd300, 16'sd500);
    drive(1'b0, 16'sd0, 16'sd0);
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_re !== 16'sd500 || out_im !== -16'sd300)
      begin failures++; $display("FAIL minus_j: valid=%b out=(%0d,%0d), want 1 (500,-300)", out_valid, out_re, out_im); end
  endtask

  task automatic test_rounding();
    fill_rom(1'b1, 8'sd0, 8'sd0);
    rom_re[0] = 8'sd45; rom_im[0] = 8'sd45;
    rom_re[1] = 8'sd32; rom_im[1] = 8'sd0;
    do_reset();
    drive(1'b1, 16'sd1, 16'sd0);
    drive(1'b1, -16'sd1, 16'sd0);
    drive(1'b0, 16'sd0, 16'sd0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_re !== 16'sd1 || out_im !== 16'sd1)
      begin failures++; $display("FAIL round_45: valid=%b out=(%0d,%0d), want 1 (1,1)", out_valid, out_re, out_im); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_sof !== 1'b0 || out_re !== 16'sd0 || out_im !== 16'sd0)
      begin failures++; $display("FAIL round_half: valid=%b sof=%b out=(%0d,%0d), want 1 0 (0,0)", out_valid, out_sof, out_re, out_im); end
  endtask

  task automatic test_saturation();
    fill_rom(1'b1, 8'sd0, 8'sd0);
    rom_re[0] = 8'sd64;  rom_im[0] = -8'sd64;
    rom_re[1] = -8'sd64; rom_im[1] = 8'sd64;
    do_reset();
    drive(1'b1, 16'sh8000, 16'sh8000);
    drive(1'b1, 16'sh8000, 16'sh8000);
    drive(1'b0, 16'sd0, 16'sd0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_re !== 16'sh8000 || out_im !== 16'sd0)
      begin failures++; $display("FAIL sat_neg: valid=%b out=(%0d,%0d), want 1 (-32768,0)", out_valid, out_re, out_im); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_re !== 16'sd32767 || out_im !== 16'sd0)
      begin failures++; $display("FAIL sat_pos: valid=%b out=(%0d,%0d), want 1 (32767,0)", out_valid, out_re, out_im); end
  endtask

  task automatic test_counter_bubbles();
    int sent = 0;
    int sofs = 0;
    fill_rom(1'b1, 8'sd0, 8'sd0);
    do_reset();
    while (sent < 130) begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_sof === 1'b1) sofs++;
      if ($urandom_range(0, 2) == 0) begin
        checks++;
        if (addr !== 6'(sent % N))
          begin failures++; $display("FAIL addr_seq: sample %0d addr=%0d, want %0d", sent, addr, sent % N); end
        in_valid = 1'b1;
        in_re    = 16'($urandom);
        in_im    = 16'($urandom);
        sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid === 1'b1 && out_sof === 1'b1) sofs++;
    end
    checks++;
    if (sofs != 3)
      begin failures++; $display("FAIL sof_count: got %0d, want 3", sofs); end
  endtask

  task automatic test_back_to_back();
    int outs = 0;
    fill_rom(1'b1, 8'sd0, 8'sd0);
    do_reset();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) outs++;
      in_valid = 1'b1;
      in_re    = (i % 16 == 0) ? 16'sh8000 : (i % 16 == 1) ? 16'sh7fff : 16'($urandom);
      in_im    = (i % 16 == 0) ? 16'sh8000 : (i % 16 == 1) ? 16'sh7fff : 16'($urandom);
    end
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid === 1'b1) outs++;
    end
    checks++;
    if (outs != 200)
      begin failures++; $display("FAIL throughput: outputs=%0d, want 200", outs); end
  endtask

  task automatic test_reset_midframe();
    fill_rom(1'b1, 8'sd0, 8'sd0);
    do_reset();
    for (int i = 0; i < 37; i++) drive(1'b1, 16'($urandom), 16'($urandom));
    @(negedge clk);
    checks++;
    if (addr !== 6'd37)
      begin failures++; $display("FAIL mid_addr: addr=%0d, want 37", addr); end
    rst      = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b0)
        begin failures++; $display("FAIL flush: cycle %0d out_valid=%b, want 0", i, out_valid); end
      @(negedge clk);
    end
    checks++;
    if (addr !== 6'd0)
      begin failures++; $display("FAIL post_rst_addr: addr=%0d, want 0", addr); end
    in_valid = 1'b1;
    in_re    = 16'($urandom);
    in_im    = 16'($urandom);
    drive(1'b0, 16'sd0, 16'sd0);
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_sof !== 1'b1)
      begin failures++; $display("FAIL post_rst_sof: valid=%b sof=%b, want 1 1", out_valid, out_sof); end
  endtask

  initial begin
    fill_rom(1'b0, 8'sd0, 8'sd0);
    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          if (rst_hit) begin
            last_re = '0;
            last_im = '0;
          end
          checks++;
          if (q.size() > 0 && q[0].due == cyc) begin
            if (out_valid !== 1'b1 || out_sof !== q[0].sof ||
                out_re !== 16'(q[0].re) || out_im !== 16'(q[0].im))
              begin failures++; $display("FAIL model_out: cyc %0d valid=%b sof=%b out=(%0d,%0d), want 1 %0d (%0d,%0d)", cyc, out_valid, out_sof, out_re, out_im, q[0].sof, q[0].re, q[0].im); end
            last_re = 16'(q[0].re);
            last_im = 16'(q[0].im);
            void'(q.pop_front());
          end else begin
            if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_re !== last_re || out_im !== last_im)
              begin failures++; $display("FAIL model_idle: cyc %0d valid=%b sof=%b out=(%0d,%0d), want 0 0 (%0d,%0d)", cyc, out_valid, out_sof, out_re, out_im, last_re, last_im); end
          end
          checks++;
          if (addr !== 6'(k))
            begin failures++; $display("FAIL model_addr: cyc %0d addr=%0d, want %0d", cyc, addr, k); end
        end
      end
    join_none

    test_reset();
    test_identity();
    test_minus_j();
    test_rounding();
    test_saturation();
    test_counter_bubbles();
    test_back_to_back();
    test_reset_midframe();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
